sm_display_scan_ctrl: RTL
=========================

# sm_display_scan_ctrl

Scan controller for the board's 8-digit, common-anode, active-low seven-segment display. It time-multiplexes eight hex nibbles with a programmable per-digit dwell and an anode-off guard interval to suppress ghosting. It applies per-digit enable, per-digit decimal point and optional leading-zero blanking. A req/ack handshake loads new content only at frame boundaries, so the displayed value never tears. It sits between the CPU's memory-mapped display register and the display pins.

## Interface
- `DIGIT_CYCLES`, default 1024: clock cycles per digit slot. Must be ≥ 2.
- `BLANK_CYCLES`, default 16: guard cycles at the start of each slot. Must be ≥ 1 and < `DIGIT_CYCLES`.
- `clock` in 1: the single clock.
- `resetn` in 1: synchronous, active-low reset.
- `number` in 32: value to show. Digit i = `number[4i+3:4i]`; digit 0 is rightmost.
- `dots` in 8: decimal-point enables, bit i → digit i.
- `digit_en` in 8: digit enables. Bit i = 0 keeps digit i dark.
- `lz_blank` in 1: enable leading-zero blanking.
- `upd_req` in 1: request to load `number`/`dots`/`digit_en`/`lz_blank`.
- `upd_ack` out 1: one-cycle pulse when the shadow registers have loaded.
- `frame_start` out 1: one-cycle pulse at the first cycle of every digit-0 slot.
- `seven_segments` out 7: active-low, bit order {g,f,e,d,c,b,a}.
- `dot` out 1: active-low decimal point.
- `anodes` out 8: active-low digit select.

## Operation
- **Shadow registers.** `sh_number`, `sh_dots`, `sh_en`, `sh_lz` drive all display decisions. Live inputs are ignored except at a load.
- **Slot counter.**
  - `cnt` runs 0..`DIGIT_CYCLES`-1. Width is clog2(`DIGIT_CYCLES`).
  - Digit index `i` (3 bits) increments when `cnt` wraps; 7 wraps to 0.
- **State is derived from `cnt`.**
  - BLANK when `cnt` < `BLANK_CYCLES`.
  - SHOW otherwise.
  - BLANK→SHOW happens at `cnt` = `BLANK_CYCLES`.
  - SHOW→BLANK of the next digit happens at the wrap.
- **Frame boundary.** The cycle where `i`=7 and `cnt`=`DIGIT_CYCLES`-1.
- **Leading-zero blanking.**
  - Digit i is zero-suppressed when `sh_lz`=1, i ≠ 0, and nibbles i..7 of `sh_number` are all zero.
  - Digit 0 is never suppressed.
- **Outputs in SHOW:**
  - `sh_en[i]`=0: anodes=8'hFF, segments=7'h7F, dot=1.
  - Zero-suppressed digit: segments=7'h7F and dot=~`sh_dots[i]`. Anodes = ~(1<<i) only if `sh_dots[i]`=1, else 8'hFF.
  - Otherwise: anodes=~(1<<i), segments=hex decode of nibble i, dot=~`sh_dots[i]`.
- **Outputs in BLANK:** anodes=8'hFF, segments=7'h7F, dot=1, for every digit.
- **Update handshake.**
  - `upd_req` is sampled only on the frame-boundary cycle. If it is high, the shadow registers load from the live inputs at that clock edge.
  - `upd_ack`=1 during the following cycle, which is also the `frame_start` cycle.
  - Requester holds the inputs stable with `upd_req` high until it sees `upd_ack`. It deasserts `upd_req` in the `upd_ack` cycle or later.
  - If `upd_req` is still high at the next frame boundary, the shadow registers reload and `upd_ack` pulses again. This is legal.
  - Deasserting `upd_req` before ack cancels the request with no side effects.
- **Reset** (synchronous, `resetn`=0 at a rising edge):
  - cnt=0, i=0.
  - sh_number=0, sh_dots=0, sh_en=8'hFF, sh_lz=0.
  - Outputs: seven_segments=7'h7F, dot=1, anodes=8'hFF, upd_ack=0, frame_start=0.
  - Reset mid-frame or mid-handshake aborts immediately. A pending request is dropped, and the requester sees no ack until a later frame boundary.

## Timing
- All outputs are registered: outputs in cycle t+1 reflect `cnt`/`i`/shadow state of cycle t.
- After reset release, the first cycle has cnt=0, i=0, and `frame_start`=1 in the next cycle.
- Frame period = 8×`DIGIT_CYCLES`. Lit time per digit = `DIGIT_CYCLES`−`BLANK_CYCLES`.
- Anodes never select two digits in the same cycle. Consecutive lit digits are always separated by ≥ `BLANK_CYCLES` cycles of 8'hFF.
- Worst-case update latency from `upd_req` rising to `upd_ack`: 8×`DIGIT_CYCLES`+1 cycles.

## Structure
- Shared package `sm_display_pkg` holds:
  - the constants `SEG_OFF`=7'h7F and `AN_OFF`=8'hFF;
  - the 4-bit hex-to-segment decode function (0→7'h40, 1→7'h79, … F→7'h0E).
- No sub-module. The counter, shadow registers and output register live in this one module, with the decoder taken from the package.

## Test plan
Bench parameters: `DIGIT_CYCLES`=8, `BLANK_CYCLES`=2.
1. **Reset values.** Hold `resetn`=0 for 3 cycles → anodes=FF, segments=7F, dot=1, acks=0. After release, `frame_start` pulses at cycle 1 and again every 64 cycles.
2. **Basic scan.** Load number=32'h89AB_CDEF, en=FF.
   - Digit 0: 2 cycles anodes=FF, then 6 cycles anodes=FE with segments=7'h0E.
   - Digit 7: anodes=7F with segments=7'h00.
   - Never more than one anode low.
3. **Handshake timing.**
   - Raise `upd_req` mid-frame with number=1234 → `upd_ack` and `frame_start` pulse together in the cycle after the boundary; the old value stays displayed until then.
   - Drop `upd_req` before the boundary → no ack, no load.
4. **Leading-zero and mask.**
   - number=32'h0000_0050, lz=1, dots=8'h04 → digits 7..3 dark; digit 2 lit with segments=7F and dot=0 (anodes=FB); digits 1 and 0 show 5 and 0.
   - en=8'hFE → digit 0 dark.
5. **Reset mid-handshake.** Assert reset at cycle `i`=7, cnt=6 with `upd_req`=1 → no `upd_ack`; shadow returns to 0/FF; scan restarts at digit 0.

Source files
------------

// File: rtl/sm_display_pkg.sv
// Shared constants and the hex-to-segment decoder for the seven-segment scan
// controller. Segment encoding is active-low, bit order {g,f,e,d,c,b,a}.
package sm_display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Slot phase: anodes are forced off during BLANK to suppress ghosting.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_SHOW  = 1'b1
    } phase_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sm_display_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scan controller with guard blanking,
// leading-zero suppression and frame-aligned shadow loading via req/ack.
import sm_display_pkg::*;

module sm_display_scan_ctrl #(
    parameter int DIGIT_CYCLES = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] number,
    input  logic [7:0]  dots,
    input  logic [7:0]  digit_en,
    input  logic        lz_blank,
    input  logic        upd_req,
    output logic        upd_ack,
    output logic        frame_start,
    output logic [6:0]  seven_segments,
    output logic        dot,
    output logic [7:0]  anodes
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   sh_number;
    logic [7:0]    sh_dots;
    logic [7:0]    sh_en;
    logic          sh_lz;
    logic          loaded;

    phase_t        phase;
    logic          cnt_wrap;
    logic          boundary;
    logic [3:0]    nib;
    logic          suppress;
    logic [7:0]    an_d;
    logic [6:0]    seg_d;
    logic          dot_d;

    assign cnt_wrap = (cnt == CNT_LAST);
    assign boundary = cnt_wrap && (idx == 3'd7);

    always_comb begin
        phase    = (cnt < CNT_BLANK) ? PH_BLANK : PH_SHOW;
        nib      = sh_number[{idx, 2'b00} +: 4];
        suppress = sh_lz && (idx != 3'd0) && ((sh_number >> {idx, 2'b00}) == 32'd0);
        an_d     = AN_OFF;
        seg_d    = SEG_OFF;
        dot_d    = 1'b1;
        if (phase == PH_SHOW && sh_en[idx]) begin
            dot_d = ~sh_dots[idx];
            if (suppress) begin
                // A suppressed zero still lights its anode when its dot is on.
                if (sh_dots[idx]) an_d = ~(8'd1 << idx);
            end else begin
                an_d  = ~(8'd1 << idx);
                seg_d = hex_to_seg(nib);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt            <= '0;
            idx            <= 3'd0;
            sh_number      <= 32'd0;
            sh_dots        <= 8'h00;
            sh_en          <= 8'hFF;
            sh_lz          <= 1'b0;
            loaded         <= 1'b0;
            upd_ack        <= 1'b0;
            frame_start    <= 1'b0;
            seven_segments <= SEG_OFF;
            dot            <= 1'b1;
            anodes         <= AN_OFF;
        end else begin
            cnt <= cnt_wrap ? '0 : cnt + 1'b1;
            if (cnt_wrap) idx <= idx + 3'd1;
            if (boundary && upd_req) begin
                sh_number <= number;
                sh_dots   <= dots;
                sh_en     <= digit_en;
                sh_lz     <= lz_blank;
            end
            // Ack is delayed one cycle so it lines up with frame_start and the
            // first output cycle that reflects the new shadow contents.
            loaded         <= boundary && upd_req;
            upd_ack        <= loaded;
            frame_start    <= (cnt == '0) && (idx == 3'd0);
            seven_segments <= seg_d;
            dot            <= dot_d;
            anodes         <= an_d;
        end
    end

endmodule
